// File: rtl/mm_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout, TX FSM encodings and the divisor clamp.
package mm_uart_tx_pkg;

  localparam logic [3:0] UART_DATA    = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;
  localparam logic [3:0] UART_CTRL    = 4'hC;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // A zero divisor would stall the bit timer, so it is treated as 1.
  function automatic logic [15:0] applied_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/mm_uart_tx_if.sv
// picorv32-style native bus slice seen by the UART slave.
interface mm_uart_tx_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (output select, wstrb, addr, data_i, input ready, data_o);
  modport slave  (input select, wstrb, addr, data_i, output ready, data_o);
endinterface

// File: rtl/mm_uart_tx_fifo.sv
// Transmit FIFO, FIFO_DEPTH x 8, show-ahead read port.
module uart_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  // Full/empty come from pre-edge state: a push into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus slave, register file, bit timer
// and TX FSM in front of a small transmit FIFO.
module mm_uart_tx
  import mm_uart_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd234
) (
  input  logic         clk,
  input  logic         reset_n,
  mm_uart_tx_if.slave  bus,
  output logic         irq,
  output logic         tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          ready_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_mux;
  logic          accept;
  logic          is_wr;
  logic [1:0]    widx;
  logic          wr_data;
  logic          wr_status;
  logic          wr_baud;
  logic          wr_ctrl;

  logic          overflow;
  logic [15:0]   baud_div;
  logic          irq_en;

  logic [1:0]    state;
  logic [2:0]    bit_idx;
  logic [15:0]   timer;
  logic [7:0]    shreg;
  logic [15:0]   div_app;
  logic          bit_end;
  logic          busy;
  logic          pop;

  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;
  logic          unused_ok;

  assign unused_ok = ^{bus.addr[1:0], bus.data_i[31:16]};

  // An access is accepted on the edge where select is seen with ready low;
  // any write or push lands on that same edge.
  assign accept    = bus.select & ~ready_q;
  assign is_wr     = |bus.wstrb;
  assign widx      = bus.addr[3:2];
  assign wr_data   = accept & is_wr & (widx == UART_DATA[3:2]) & bus.wstrb[0];
  assign wr_status = accept & is_wr & (widx == UART_STATUS[3:2]) & bus.wstrb[0];
  assign wr_baud   = accept & is_wr & (widx == UART_BAUDDIV[3:2]);
  assign wr_ctrl   = accept & is_wr & (widx == UART_CTRL[3:2]) & bus.wstrb[0];

  assign bus.ready  = ready_q;
  assign bus.data_o = rdata_q;

  always_comb begin
    rd_mux = '0;
    case (widx)
      UART_STATUS[3:2]: begin
        rd_mux[ST_BUSY]            = busy;
        rd_mux[ST_FULL]            = fifo_full;
        rd_mux[ST_EMPTY]           = fifo_empty;
        rd_mux[ST_OVF]             = overflow;
        rd_mux[ST_CNT_LSB +: 7]    = 7'(fifo_count);
      end
      UART_BAUDDIV[3:2]: rd_mux[15:0] = baud_div;
      UART_CTRL[3:2]:    rd_mux[0]    = irq_en;
      default:           rd_mux       = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      overflow <= 1'b0;
      baud_div <= DEFAULT_DIV;
      irq_en   <= 1'b0;
    end else begin
      ready_q <= accept;
      rdata_q <= (accept & ~is_wr) ? rd_mux : 32'd0;
      if (wr_data & fifo_full)
        overflow <= 1'b1;
      else if (wr_status & bus.data_i[ST_OVF])
        overflow <= 1'b0;
      if (wr_baud & bus.wstrb[0]) baud_div[7:0]  <= bus.data_i[7:0];
      if (wr_baud & bus.wstrb[1]) baud_div[15:8] <= bus.data_i[15:8];
      if (wr_ctrl) irq_en <= bus.data_i[0];
    end
  end

  uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (wr_data),
    .pop     (pop),
    .din     (bus.data_i[7:0]),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // The divisor is sampled only when the timer reloads, so a BAUDDIV write
  // never stretches or shortens the bit in flight.
  assign div_app = applied_div(baud_div);
  assign bit_end = (timer == 16'd1);
  assign busy    = (state != S_IDLE);
  assign pop     = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
  assign irq     = irq_en & fifo_empty & ~busy;

  always_ff @(posedge clk) begin
    if (pop) shreg <= fifo_dout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      bit_idx <= 3'd0;
      timer   <= 16'd1;
      tx      <= 1'b1;
    end else begin
      timer <= ((state == S_IDLE) | bit_end) ? div_app : timer - 16'd1;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state <= S_START;
            tx    <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            bit_idx <= 3'd0;
            tx      <= shreg[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              state <= S_START;
              tx    <= 1'b0;
            end else begin
              state <= S_IDLE;
              tx    <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_uart_tx.sv
// Directed bench for mm_uart_tx: bus handshake, register map, framing,
// burst overflow, interrupt timing, baud changes and asynchronous reset.
module tb_mm_uart_tx;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;
  logic tx;

  mm_uart_tx_if bus ();

  mm_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd234)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  // Per-cycle trace of tx/irq, taken shortly after each rising edge.
  int   pcyc = 0;
  logic txlog  [8192];
  logic irqlog [8192];

  always @(posedge clk) begin
    #2;
    if (pcyc < 8192) begin
      txlog[pcyc]  = tx;
      irqlog[pcyc] = irq;
    end
    pcyc++;
  end

  int passed = 0;
  int total  = 0;
  int acc_mark;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic access(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd);
    @(negedge clk);
    bus.select = 1'b1;
    bus.addr   = a;
    bus.wstrb  = s;
    bus.data_i = d;
    @(posedge clk);
    #1;
    acc_mark = pcyc;
    check("ready", 32'(bus.ready), 32'd1);
    rd = bus.data_o;
    @(negedge clk);
    bus.select = 1'b0;
    bus.wstrb  = 4'h0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] dummy;
    access(a, s, d, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    access(a, 4'h0, 32'd0, v);
    check(tag, v, exp);
  endtask

  // Compares the traced tx line against one 8N1 frame starting at index f;
  // the first n1 bits last d1 cycles, the rest d2 cycles.
  task automatic check_frame(input string tag, input int f, input logic [7:0] b,
                             input int d1, input int n1, input int d2);
    int pos;
    int bad;
    logic [9:0] bits;
    pos  = f;
    bad  = 0;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      int d;
      d = (k < n1) ? d1 : d2;
      for (int j = 0; j < d; j++) begin
        if (txlog[pos] !== bits[k]) bad++;
        pos++;
      end
    end
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic count_ones(input int from, input int n, input bit use_irq, output int ones);
    ones = 0;
    for (int i = from; i < from + n; i++)
      ones += int'(use_irq ? irqlog[i] : txlog[i]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int m;
    int ones;
    bus.select = 1'b0;
    bus.wstrb  = 4'h0;
    bus.addr   = 4'h0;
    bus.data_i = 32'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_data_o", bus.data_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("rst_status", 4'h4, 32'h0000_0004);
    rd_check("rst_baud", 4'h8, 32'd234);
    rd_check("rst_ctrl", 4'hC, 32'd0);
    rd_check("data_read0", 4'h0, 32'd0);
    wr(4'h8, 4'b0010, 32'hFFFF_1200);
    rd_check("baud_bytestrb", 4'h8, 32'h0000_12EA);

    // Single byte at divisor 4
    wr(4'h8, 4'b0011, 32'd4);
    wr(4'h0, 4'b0001, 32'h0000_00A5);
    m = acc_mark;
    rd_check("single_busy", 4'h4, 32'h0000_0005);
    repeat (45) @(posedge clk);
    #3;
    check("single_lat_hi", 32'(txlog[m]), 32'd1);
    check("single_lat_lo", 32'(txlog[m + 1]), 32'd0);
    check_frame("single_frame", m + 1, 8'hA5, 4, 10, 4);
    rd_check("single_done", 4'h4, 32'h0000_0004);

    // Burst of 10 into an 8-deep FIFO at divisor 16
    wr(4'h8, 4'b0011, 32'd16);
    m = 0;
    for (int i = 0; i < 10; i++) begin
      wr(4'h0, 4'b0001, 32'(8'h10 + i));
      if (i == 0) m = acc_mark;
    end
    rd_check("burst_status", 4'h4, 32'h0000_080B);
    wr(4'h4, 4'b0001, 32'h0000_0008);
    rd_check("ovf_clear", 4'h4, 32'h0000_0803);
    repeat (1500) @(posedge clk);
    #3;
    for (int k = 0; k < 9; k++)
      check_frame($sformatf("burst_frame%0d", k), m + 1 + 160 * k, 8'(8'h10 + k), 16, 10, 16);
    count_ones(m + 1441, 40, 1'b0, ones);
    check("burst_no_10th", 32'(ones), 32'd40);
    rd_check("burst_done", 4'h4, 32'h0000_0004);

    // Interrupt level timing at divisor 4
    wr(4'h8, 4'b0011, 32'd4);
    wr(4'hC, 4'b0001, 32'd1);
    check("irq_idle_on", 32'(irq), 32'd1);
    wr(4'h0, 4'b0001, 32'h0000_0001);
    m = acc_mark;
    wr(4'h0, 4'b0001, 32'h0000_0002);
    repeat (100) @(posedge clk);
    #3;
    count_ones(m, 81, 1'b1, ones);
    check("irq_low_frames", 32'(ones), 32'd0);
    count_ones(m + 81, 15, 1'b1, ones);
    check("irq_high_after", 32'(ones), 32'd15);
    wr(4'h0, 4'b0001, 32'h0000_0003);
    m = acc_mark;
    @(posedge clk);
    #3;
    check("irq_before_push", 32'(irqlog[m - 1]), 32'd1);
    check("irq_after_push", 32'(irqlog[m]), 32'd0);
    repeat (50) @(posedge clk);
    wr(4'hC, 4'b0001, 32'd0);
    check("irq_disabled", 32'(irq), 32'd0);

    // Divisor change in the middle of bit 2
    wr(4'h8, 4'b0011, 32'd8);
    wr(4'h0, 4'b0001, 32'h0000_003C);
    m = acc_mark;
    repeat (17) @(posedge clk);
    wr(4'h8, 4'b0011, 32'd3);
    repeat (60) @(posedge clk);
    #3;
    check_frame("baud_change", m + 1, 8'h3C, 8, 3, 3);
    check("baud_change_idle", 32'(txlog[m + 46]), 32'd1);

    // Zero divisor behaves as 1
    wr(4'h8, 4'b0011, 32'd0);
    rd_check("baud_zero_rd", 4'h8, 32'd0);
    wr(4'h0, 4'b0001, 32'h0000_005A);
    m = acc_mark;
    repeat (20) @(posedge clk);
    #3;
    check_frame("baud_zero", m + 1, 8'h5A, 1, 10, 1);

    // select held for 6 cycles on STATUS
    @(negedge clk);
    bus.select = 1'b1;
    bus.addr   = 4'h4;
    bus.wstrb  = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hs_ready%0d", i), 32'(bus.ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("hs_data%0d", i), bus.data_o, (i % 2 == 0) ? 32'd4 : 32'd0);
    end
    @(negedge clk);
    bus.select = 1'b0;
    @(posedge clk);
    #1;
    check("hs_release", 32'(bus.ready), 32'd0);

    // Asynchronous reset in the middle of a frame
    wr(4'h8, 4'b0011, 32'd50);
    wr(4'h0, 4'b0001, 32'h0000_0000);
    wr(4'h0, 4'b0001, 32'h0000_0055);
    repeat (120) @(posedge clk);
    #3;
    check("midframe_tx_low", 32'(tx), 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_ready", 32'(bus.ready), 32'd0);
    check("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("arst_status", 4'h4, 32'h0000_0004);
    rd_check("arst_baud", 4'h8, 32'd234);
    rd_check("arst_ctrl", 4'hC, 32'd0);
    repeat (20) @(posedge clk);
    #3;
    count_ones(pcyc - 20, 20, 1'b0, ones);
    check("arst_line_idle", 32'(ones), 32'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
